// File: rtl/comptest_pkg.sv
// Shared definitions for the comparator test sequencer: strip geometry and scan FSM encoding.
package comptest_pkg;

   localparam int unsigned NSTRIP  = 32;
   localparam int unsigned STRIP_W = $clog2(NSTRIP);
   localparam int unsigned PCNT_W  = 16;

   typedef enum logic [3:0] {
      IDLE,
      CLEAR,
      ARM,
      FIRE,
      ACK,
      RDY,
      GAP,
      NEXT,
      DONE
   } state_t;

   function automatic logic [NSTRIP-1:0] strip_onehot(input logic [STRIP_W-1:0] idx);
      return NSTRIP'(1) << idx;
   endfunction

endpackage

// File: rtl/pulse_scan_sequencer_if.sv
// Fire/ready handshake between the scan sequencer (master) and the pulse injector (slave).
interface pulse_scan_sequencer_if;

   logic fire_pulse;
   logic pulser_ready;

   modport master (output fire_pulse, input pulser_ready);
   modport slave  (input fire_pulse, output pulser_ready);

endinterface

// File: rtl/pulse_scan_sequencer_handshake_timer.sv
// Cycle counter bounding how long the injector may take to drop or raise pulser_ready.
module handshake_timer #(
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic clock40,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;

   // Expires on the ACK_TIMEOUT-th enabled cycle after a clear; holds there until cleared.
   assign o_expired = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clock40 or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pulse_scan_sequencer.sv
// Halfstrip scan sequencer: fires a configured number of injector pulses per strip and
// presents the matching expected comparator pattern.
module pulse_scan_sequencer
   import comptest_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic                 clock40,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [STRIP_W-1:0]   strip_first,
   input  logic [STRIP_W-1:0]   strip_last,
   input  logic [PCNT_W-1:0]    pulses_per_strip,
   input  logic [7:0]           gap_bx,
   pulse_scan_sequencer_if.master bus,
   output logic [NSTRIP-1:0]    halfstrips_expect,
   output logic                 compout_expect,
   output logic                 halfstrips_errcnt_rst,
   output logic                 compout_errcnt_rst,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err,
   output logic [STRIP_W-1:0]   strip_cur,
   output logic [PCNT_W-1:0]    pulse_cnt
);

   state_t              r_state;
   logic                r_fire;
   logic                r_errcnt_rst;
   logic [NSTRIP-1:0]   r_hs_expect;
   logic                r_comp_expect;
   logic                r_busy;
   logic                r_done;
   logic                r_timeout;
   logic [STRIP_W-1:0]  r_strip;
   logic [PCNT_W-1:0]   r_pcnt;
   logic [STRIP_W-1:0]  r_last;
   logic [PCNT_W-1:0]   r_pulses;
   logic [7:0]          r_gap;
   logic [7:0]          r_gap_cnt;
   logic                r_empty;

   logic w_ready;
   logic w_tmr_clear;
   logic w_tmr_en;
   logic w_expired;

   assign w_ready     = bus.pulser_ready;
   // Restart the timer on fire and again when the ready drop is seen.
   assign w_tmr_clear = (r_state == FIRE) || ((r_state == ACK) && !w_ready);
   assign w_tmr_en    = (r_state == ACK) || (r_state == RDY);

   handshake_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_timer (
      .clock40   (clock40),
      .reset_n   (reset_n),
      .i_clear   (w_tmr_clear),
      .i_enable  (w_tmr_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clock40 or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_fire        <= 1'b0;
         r_errcnt_rst  <= 1'b0;
         r_hs_expect   <= '0;
         r_comp_expect <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeout     <= 1'b0;
         r_strip       <= '0;
         r_pcnt        <= '0;
         r_last        <= '0;
         r_pulses      <= '0;
         r_gap         <= '0;
         r_gap_cnt     <= '0;
         r_empty       <= 1'b0;
      end else begin
         r_fire       <= 1'b0;
         r_errcnt_rst <= 1'b0;
         if (abort) begin
            r_state       <= IDLE;
            r_hs_expect   <= '0;
            r_comp_expect <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  if (start) begin
                     r_state       <= CLEAR;
                     r_last        <= strip_last;
                     r_pulses      <= pulses_per_strip;
                     r_gap         <= gap_bx;
                     r_empty       <= (strip_first > strip_last) || (pulses_per_strip == '0);
                     r_strip       <= strip_first;
                     r_pcnt        <= '0;
                     r_timeout     <= 1'b0;
                     r_done        <= 1'b0;
                     r_busy        <= 1'b1;
                     r_errcnt_rst  <= 1'b1;
                     r_hs_expect   <= strip_onehot(strip_first);
                     r_comp_expect <= 1'b1;
                  end
               end
               CLEAR: begin
                  if (r_empty) begin
                     r_state       <= DONE;
                     r_busy        <= 1'b0;
                     r_done        <= 1'b1;
                     r_hs_expect   <= '0;
                     r_comp_expect <= 1'b0;
                  end else begin
                     r_state <= ARM;
                  end
               end
               ARM: begin
                  if (w_ready) begin
                     r_state <= FIRE;
                     r_fire  <= 1'b1;
                  end
               end
               FIRE: r_state <= ACK;
               ACK, RDY: begin
                  if ((r_state == ACK) && !w_ready) begin
                     r_state <= RDY;
                  end else if ((r_state == RDY) && w_ready) begin
                     r_pcnt    <= (r_pcnt == '1) ? r_pcnt : r_pcnt + 1'b1;
                     r_gap_cnt <= '0;
                     r_state   <= (r_gap == '0) ? NEXT : GAP;
                  end else if (w_expired) begin
                     r_state       <= DONE;
                     r_timeout     <= 1'b1;
                     r_busy        <= 1'b0;
                     r_done        <= 1'b1;
                     r_hs_expect   <= '0;
                     r_comp_expect <= 1'b0;
                  end
               end
               GAP: begin
                  if (r_gap_cnt == r_gap - 8'd1) begin
                     r_state <= NEXT;
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 8'd1;
                  end
               end
               NEXT: begin
                  if (r_pcnt < r_pulses) begin
                     r_state <= FIRE;
                     r_fire  <= 1'b1;
                  end else if (r_strip == r_last) begin
                     r_state       <= DONE;
                     r_busy        <= 1'b0;
                     r_done        <= 1'b1;
                     r_hs_expect   <= '0;
                     r_comp_expect <= 1'b0;
                  end else begin
                     r_state     <= FIRE;
                     r_fire      <= 1'b1;
                     r_strip     <= r_strip + 1'b1;
                     r_pcnt      <= '0;
                     r_hs_expect <= strip_onehot(r_strip + 1'b1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.fire_pulse          = r_fire;
   assign halfstrips_expect       = r_hs_expect;
   assign compout_expect          = r_comp_expect;
   assign halfstrips_errcnt_rst   = r_errcnt_rst;
   assign compout_errcnt_rst      = r_errcnt_rst;
   assign busy                    = r_busy;
   assign done                    = r_done;
   assign timeout_err             = r_timeout;
   assign strip_cur               = r_strip;
   assign pulse_cnt               = r_pcnt;

endmodule

// File: tb/tb_pulse_scan_sequencer.sv
// Self-checking bench for pulse_scan_sequencer: scoreboard of expected patterns per fired pulse.
module tb_pulse_scan_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [4:0]  strip_first;
   logic [4:0]  strip_last;
   logic [15:0] pulses_per_strip;
   logic [7:0]  gap_bx;
   logic [31:0] halfstrips_expect;
   logic        compout_expect;
   logic        hs_errcnt_rst;
   logic        co_errcnt_rst;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic [4:0]  strip_cur;
   logic [15:0] pulse_cnt;

   pulse_scan_sequencer_if bus ();

   pulse_scan_sequencer #(
      .ACK_TIMEOUT (64)
   ) dut (
      .clock40               (clk),
      .reset_n               (rst_n),
      .start                 (start),
      .abort                 (abort),
      .strip_first           (strip_first),
      .strip_last            (strip_last),
      .pulses_per_strip      (pulses_per_strip),
      .gap_bx                (gap_bx),
      .bus                   (bus),
      .halfstrips_expect     (halfstrips_expect),
      .compout_expect        (compout_expect),
      .halfstrips_errcnt_rst (hs_errcnt_rst),
      .compout_errcnt_rst    (co_errcnt_rst),
      .busy                  (busy),
      .done                  (done),
      .timeout_err           (timeout_err),
      .strip_cur             (strip_cur),
      .pulse_cnt             (pulse_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          fire_cnt = 0;
   int          rdy_mode = 0;
   logic        prev_fire = 1'b0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Injector model: ready drops 1 cycle after fire, returns 3 cycles later (mode 0); mode 1 stuck.
   initial begin
      bus.pulser_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.fire_pulse && rdy_mode == 0) begin
            @(posedge clk);
            #1 bus.pulser_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.pulser_ready = 1'b1;
         end
      end
   end

   // Scoreboard: every fired pulse pops one expected pattern.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_fire = 1'b0;
      end else begin
         if (bus.fire_pulse) begin
            fire_cnt++;
            check("fire_back_to_back", 32'(prev_fire), 32'd0);
            check("fire_unexpected", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() != 0) begin
               check("halfstrips_at_fire", halfstrips_expect, exp_q.pop_front());
               check("compout_at_fire", 32'(compout_expect), 32'd1);
            end
         end
         prev_fire = bus.fire_pulse;
      end
   end

   task automatic push_scan(input int first, input int last, input int pulses);
      if (first <= last && pulses != 0) begin
         for (int s = first; s <= last; s++) begin
            for (int p = 0; p < pulses; p++) exp_q.push_back(32'd1 << s);
         end
      end
   endtask

   // Drives a 1-cycle start (cycle c0) and checks CLEAR (c1) and the following cycle (c2).
   task automatic start_scan(input int first, input int last, input int pulses, input int gap);
      bit empty;
      empty = (first > last) || (pulses == 0);
      @(posedge clk);
      #1;
      strip_first      = 5'(first);
      strip_last       = 5'(last);
      pulses_per_strip = 16'(pulses);
      gap_bx           = 8'(gap);
      start            = 1'b1;
      push_scan(first, last, pulses);
      @(negedge clk);
      check("errcnt_rst_c0", 32'(hs_errcnt_rst), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("hs_errcnt_rst_c1", 32'(hs_errcnt_rst), 32'd1);
      check("co_errcnt_rst_c1", 32'(co_errcnt_rst), 32'd1);
      check("busy_c1", 32'(busy), 32'd1);
      check("strip_cur_c1", 32'(strip_cur), 32'(first));
      check("pulse_cnt_c1", 32'(pulse_cnt), 32'd0);
      check("timeout_clr_c1", 32'(timeout_err), 32'd0);
      @(negedge clk);
      check("errcnt_rst_c2", 32'(hs_errcnt_rst | co_errcnt_rst), 32'd0);
      check("fire_c2", 32'(bus.fire_pulse), 32'd0);
      check("done_c2", 32'(done), 32'(empty));
      check("busy_c2", 32'(busy), 32'(!empty));
   endtask

   task automatic wait_fire(input string tag, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.fire_pulse) begin
            seen = 1'b1;
            break;
         end
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) break;
      end
      check(tag, 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int f0;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      strip_first = '0;
      strip_last = '0;
      pulses_per_strip = '0;
      gap_bx = '0;
      repeat (3) @(negedge clk);
      check("rst_fire", 32'(bus.fire_pulse), 32'd0);
      check("rst_busy_done", 32'({busy, done, timeout_err}), 32'd0);
      check("rst_expect", halfstrips_expect, 32'd0);
      check("rst_misc", 32'({compout_expect, hs_errcnt_rst, co_errcnt_rst, strip_cur, pulse_cnt}), 32'd0);
      rst_n = 1'b1;

      // Nominal scan 3..5, 2 pulses each, gap 2.
      f0 = fire_cnt;
      start_scan(3, 5, 2, 2);
      wait_done("t1_done", 300);
      check("t1_fires", 32'(fire_cnt - f0), 32'd6);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_expect_idle", halfstrips_expect, 32'd0);
      check("t1_strip_pcnt", 32'({strip_cur, pulse_cnt}), {11'd0, 5'd5, 16'd2});
      check("t1_queue", 32'(exp_q.size()), 32'd0);

      // Empty configurations finish without firing.
      f0 = fire_cnt;
      start_scan(7, 2, 3, 1);
      start_scan(1, 2, 0, 0);
      repeat (5) @(negedge clk);
      check("t3_no_fires", 32'(fire_cnt - f0), 32'd0);

      // Injector never drops ready: timeout after ACK_TIMEOUT cycles in ACK.
      rdy_mode = 1;
      f0 = fire_cnt;
      start_scan(2, 2, 1, 0);
      wait_fire("t4_fire", 10);
      repeat (64) @(negedge clk);
      check("t4_done_early", 32'(done), 32'd0);
      @(negedge clk);
      check("t4_done", 32'(done), 32'd1);
      check("t4_timeout", 32'(timeout_err), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      repeat (10) @(negedge clk);
      check("t4_fires", 32'(fire_cnt - f0), 32'd1);
      rdy_mode = 0;

      // Abort in the GAP after the first pulse of strip 4, then rescan.
      start_scan(3, 5, 2, 2);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.fire_pulse && halfstrips_expect == 32'h10) break;
      end
      check("t5_fire_s4", halfstrips_expect, 32'h10);
      repeat (5) @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      check("t5_in_gap", 32'({busy, strip_cur, pulse_cnt}), {10'd0, 1'b1, 5'd4, 16'd1});
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("t5_idle", 32'({busy, done, compout_expect, bus.fire_pulse}), 32'd0);
      check("t5_expect", halfstrips_expect, 32'd0);
      exp_q.delete();
      f0 = fire_cnt;
      start_scan(3, 5, 2, 2);
      wait_done("t5_rescan_done", 300);
      check("t5_rescan_fires", 32'(fire_cnt - f0), 32'd6);

      // Asynchronous reset while fire_pulse is high.
      start_scan(0, 1, 1, 1);
      wait_fire("t6_fire", 10);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_fire", 32'(bus.fire_pulse), 32'd0);
      check("t6_rst_state", 32'({busy, done, compout_expect, strip_cur, pulse_cnt}), 32'd0);
      check("t6_rst_expect", halfstrips_expect, 32'd0);
      exp_q.delete();
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_start_in_rst", 32'({busy, hs_errcnt_rst}), 32'd0);

      // Start and config changes while busy are ignored.
      f0 = fire_cnt;
      start_scan(0, 1, 1, 1);
      wait_fire("t6b_fire", 10);
      @(posedge clk);
      #1;
      strip_first = 5'd9;
      strip_last = 5'd9;
      pulses_per_strip = 16'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("t6b_done", 200);
      check("t6b_fires", 32'(fire_cnt - f0), 32'd2);
      check("t6b_strip", 32'(strip_cur), 32'd1);
      check("t6b_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
